div_share_ctrl: RTL and testbench

- Round-robin scheduler that time-shares one 32-bit iterative unsigned divider (`Divide`) between NREQ requesters.
- Arbitrates, latches operands, drives the divider start/operand interface and counts iterations.
- Returns quotient/remainder to the winner with a one-cycle ack; zero divisors bypass the divider.
- Sits between CPU-side/accelerator clients and the single divider instance.

---
 rtl/div_share_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_div_share_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// Purpose : round-robin scheduler time-sharing one 32-bit iterative divider between NREQ requesters.
// Latency : nonzero divisor -> ack in the cycle after grant edge + 34; zero divisor -> ack the cycle after grant.
// Backpr. : no queueing; requesters hold req/operands until ack, other requests wait while busy.
//
// Ports:
//   clk, reset (async, active-low)
//   req[NREQ], a_in/b_in[32*NREQ]   requester side (requester i uses bits [32i+31:32i])
//   ack[NREQ] one-hot pulse, q_out, r_out, err_out, resp_id   response (held until next ack)
//   busy, proto_err (sticky)         status
//   div_start, div_a, div_b -> divider;  div_d, div_r, div_ok <- divider
//
// Optional feature: define DIV_SIGNED_EN for two's-complement operands (divider sees
// magnitudes, signs are re-applied to the result in the DONE cycle).

module div_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   a_in,
  input  logic [32*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          q_out,
  output logic [31:0]          r_out,
  output logic                 err_out,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy,
  output logic                 proto_err,
  output logic                 div_start,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  input  logic [31:0]          div_d,
  input  logic [31:0]          div_r,
  input  logic                 div_ok
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_win;
  logic [5:0]      r_cnt;

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [31:0]     w_a;
  logic [31:0]     w_b;
  logic [31:0]     w_a_mag;
  logic [31:0]     w_b_mag;
  logic [31:0]     w_q_fix;
  logic [31:0]     w_r_fix;
  logic [NREQ-1:0] w_new_onehot;
  logic [NREQ-1:0] w_cur_onehot;

  // The requester being acked this cycle still holds req; masking it keeps it
  // from being granted a second time, while others may win back-to-back.
  assign w_elig = req & ~ack;

  // Round-robin search starting just after the last winner, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && w_elig[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // Operand mux for the candidate winner.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_a = a_in[32*i +: 32];
        w_b = b_in[32*i +: 32];
      end
    end
  end

  assign w_new_onehot = NREQ'(1) << w_win;
  assign w_cur_onehot = NREQ'(1) << r_win;

`ifdef DIV_SIGNED_EN
  logic r_a_neg;
  logic r_b_neg;

  assign w_a_mag = w_a[31] ? (32'd0 - w_a) : w_a;
  assign w_b_mag = w_b[31] ? (32'd0 - w_b) : w_b;

  // Quotient negative when signs differ; remainder follows the dividend.
  // -2^31 / -1 needs no special case: magnitude 0x80000000 / 1 is already the
  // wrapped answer and the signs agree.
  assign w_q_fix = (r_a_neg ^ r_b_neg) ? (32'd0 - div_d) : div_d;
  assign w_r_fix = r_a_neg ? (32'd0 - div_r) : div_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
    end else if (r_state == S_IDLE && w_found) begin
      r_a_neg <= w_a[31];
      r_b_neg <= w_b[31];
    end
  end
`else
  assign w_a_mag = w_a;
  assign w_b_mag = w_b;
  assign w_q_fix = div_d;
  assign w_r_fix = div_r;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= IDW'(NREQ - 1);
      r_win     <= '0;
      r_cnt     <= '0;
      ack       <= '0;
      q_out     <= '0;
      r_out     <= '0;
      err_out   <= 1'b0;
      resp_id   <= '0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
    end else begin
      ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ptr <= w_win;
            r_win <= w_win;
            div_a <= w_a_mag;
            div_b <= w_b_mag;
            if (w_b == 32'd0) begin
              // Zero divisor: answer immediately without touching the divider.
              ack     <= w_new_onehot;
              resp_id <= w_win;
              q_out   <= 32'hFFFF_FFFF;
              r_out   <= w_a;
              err_out <= 1'b1;
            end else begin
              div_start <= 1'b1;
              r_cnt     <= '0;
              busy      <= 1'b1;
              r_state   <= S_RUN;
            end
          end
        end

        S_RUN: begin
          // start stays high for cnt 0..32: one load cycle plus 32 iterations.
          if (r_cnt == 6'd32) begin
            div_start <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_DONE: begin
          q_out   <= w_q_fix;
          r_out   <= w_r_fix;
          err_out <= 1'b0;
          ack     <= w_cur_onehot;
          resp_id <= r_win;
          busy    <= 1'b0;
          r_state <= S_IDLE;
          if (!div_ok) begin
            proto_err <= 1'b1;
          end
        end

        default: begin
          div_start <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Purpose : self-checking bench for div_share_ctrl with a behavioural divider.
// Latency : divider model produces D/R after 33 cycles of start.
// Backpr. : requesters drop req the cycle after their ack (except the fairness run).

module tb_div_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [32*NREQ-1:0]  a_in;
  logic [32*NREQ-1:0]  b_in;
  logic [NREQ-1:0]     ack;
  logic [31:0]         q_out;
  logic [31:0]         r_out;
  logic                err_out;
  logic [IDW-1:0]      resp_id;
  logic                busy;
  logic                proto_err;
  logic                div_start;
  logic [31:0]         div_a;
  logic [31:0]         div_b;
  logic [31:0]         div_d;
  logic [31:0]         div_r;
  logic                div_ok;

  div_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .q_out(q_out), .r_out(r_out), .err_out(err_out),
    .resp_id(resp_id), .busy(busy), .proto_err(proto_err),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_d(div_d), .div_r(div_r), .div_ok(div_ok)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int ack_cyc = 0;
  int last_id = 0;
  bit start_seen = 1'b0;
  bit ok_kill = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural divider: results appear after 33 cycles of start.
  int          m_cnt;
  logic [31:0] m_d;
  logic [31:0] m_r;
  logic        m_ok;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_d <= '0; m_r <= '0; m_ok <= 1'b1;
    end else if (div_start) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 0) m_ok <= 1'b0;
      if (m_cnt == 32) begin
        m_d  <= div_a / div_b;
        m_r  <= div_a % div_b;
        m_ok <= !ok_kill;
      end
    end else begin
      m_cnt <= 0;
    end
  end
  assign div_d  = m_d;
  assign div_r  = m_r;
  assign div_ok = m_ok;

  // Scoreboard
  typedef struct {
    int          id;
    logic [31:0] q;
    logic [31:0] r;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;

  always @(negedge clk) begin
    if (div_start) start_seen = 1'b1;
    if (ack != '0) begin
      ack_cnt++;
      ack_cyc = cyc;
      last_id = int'(resp_id);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        m_e = sb.pop_front();
        chk("ack_onehot", 32'(ack), 32'(1 << m_e.id));
        chk("resp_id", 32'(resp_id), 32'(m_e.id));
        chk("q_out", q_out, m_e.q);
        chk("r_out", r_out, m_e.r);
        chk("err_out", 32'(err_out), 32'(m_e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic e);
    a_in[32*id +: 32] = a;
    b_in[32*id +: 32] = b;
    req[id] = 1'b1;
    sb.push_back('{id, q, r, e});
  endtask

  // Advance until the running ack count reaches target; optionally drop the
  // acked requester's req in the cycle after its ack.
  task automatic run(input int target, input bit drop, input int budget);
    int k;
    int prev;
    k = 0;
    while (ack_cnt < target && k < budget) begin
      prev = ack_cnt;
      tick();
      k++;
      if (drop && ack_cnt != prev) req[last_id] = 1'b0;
    end
    chk("ack_count", 32'(ack_cnt), 32'(target));
  endtask

  int t0;
  int t1;
  int tgt;

  initial begin
    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0;
    tgt = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_q", q_out, 32'd0);
    chk("rst_r", r_out, 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);
    chk("rst_start", 32'(div_start), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single unsigned request
    issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    t0 = cyc + 1;
    tgt += 1; run(tgt, 1'b1, 80);
    chk("lat_single", 32'(ack_cyc - t0), 32'd34);
    chk("proto_single", 32'(proto_err), 32'd0);

    // Zero divisor bypass
    start_seen = 1'b0;
    issue(2, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    t0 = cyc + 1;
    tgt += 1; run(tgt, 1'b1, 10);
    chk("lat_zero", 32'(ack_cyc - t0), 32'd0);
    chk("zero_no_start", 32'(start_seen), 32'd0);

    // Back-to-back: req1 granted during req0's ack cycle
    issue(0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    issue(1, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0);
    tgt += 1; run(tgt, 1'b1, 80);
    t1 = ack_cyc;
    tgt += 1; run(tgt, 1'b1, 80);
    chk("b2b_gap", 32'(ack_cyc - t1), 32'd35);

    // Reset in the middle of a run
    a_in[32*3 +: 32] = 32'd5;
    b_in[32*3 +: 32] = 32'd1;
    req[3] = 1'b1;
    tick();
    repeat (10) tick();
    chk("midrun_busy", 32'(busy), 32'd1);
    chk("midrun_start", 32'(div_start), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_start", 32'(div_start), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    req = '0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("abort_no_ack", 32'(ack_cnt), 32'(tgt));
    issue(3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    tgt += 1; run(tgt, 1'b1, 80);

    // Fairness with all requesters held: order 0,1,2,3,0
    issue(0, 32'd50, 32'd3, 32'd16, 32'd2, 1'b0);
    issue(1, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0);
    issue(2, 32'd1, 32'd2, 32'd0, 32'd1, 1'b0);
    issue(3, 32'h7FFF_FFFF, 32'h10, 32'h07FF_FFFF, 32'hF, 1'b0);
    issue(0, 32'd50, 32'd3, 32'd16, 32'd2, 1'b0);
    tgt += 4; run(tgt, 1'b0, 200);
    req = 4'b0001;
    tgt += 1; run(tgt, 1'b1, 80);

`ifdef DIV_SIGNED_EN
    issue(0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    tgt += 1; run(tgt, 1'b1, 80);
    issue(1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    tgt += 1; run(tgt, 1'b1, 80);
    issue(2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    tgt += 1; run(tgt, 1'b1, 80);
`endif

    // Divider not ready at DONE: result still returned, proto_err sticks
    ok_kill = 1'b1;
    issue(1, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0);
    tgt += 1; run(tgt, 1'b1, 80);
    ok_kill = 1'b0;
    tick();
    chk("proto_err_set", 32'(proto_err), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
